kb_digit_display: RTL
=====================

# kb_digit_display

Multi-digit keypad entry and display controller, the parametrised successor of the single-digit keypad display. It takes decoded key strobes from the 4x4 keypad scanner, builds a decimal entry buffer of up to NDIGITS digits with backspace, clear and enter editing, and time-multiplexes the buffer onto an NDIGITS-wide common-anode 7-segment display. It sits between the keypad scanner and the board display pins; the committed value is exported for downstream logic.

## Interface
- NDIGITS, 4: display digits / buffer depth; legal 1..8.
- REFRESH_CYCLES, 100_000: clk cycles each digit is lit; legal 2..2^26-1.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe: key_code is valid.
- key_code  in  4  scanner code; 0x0-0x9 digit, 0xA backspace, 0xC clear, 0xF enter, others ignored.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- an  out  NDIGITS  digit enables, active-low one-hot, registered.
- value  out  4*NDIGITS  last committed BCD value, digit 0 in bits [3:0].
- enter  out  1  one-cycle pulse when value is updated.
- full  out  1  buffer holds NDIGITS digits.

## Operation
- Entry buffer: NDIGITS BCD nibbles plus a count cnt (0..NDIGITS). Newest digit is always digit 0 (rightmost).
- Digit key: if cnt<NDIGITS, shift buffer left one nibble, insert code at digit 0, cnt+1. If full, the key is ignored and the buffer is unchanged.
- Backspace (0xA): if cnt>0, shift right one nibble, zero-fill the top, cnt-1. If cnt=0, no change.
- Clear (0xC): buffer := 0, cnt := 0.
- Enter (0xF): value := buffer, enter pulses, buffer := 0, cnt := 0. Enter with cnt=0 commits all zeros and still pulses.
- Codes 0xB, 0xD, 0xE: ignored. key_valid=0: no action.
- full = (cnt==NDIGITS), combinational from cnt.
- Scan: refresh counter counts 0..REFRESH_CYCLES-1. At terminal count it wraps to 0 and digit index idx advances, with NDIGITS-1 wrapping to 0. For NDIGITS=1, idx stays 0.
- Output register per clk: an := ~(1<<idx); seg := hex decode of buffer[idx] (0-F standard glyphs); dp := 0 only when idx==0 and full, else 1.

## Timing
- Reset values: buffer 0, cnt 0, idx 0, refresh counter 0, value 0, enter 0, full 0, an = ~1 (digit 0 enabled), seg = glyph "0" (7'b1000000), dp 1.
- Key to buffer: key_valid sampled at edge k; buffer, cnt and full change after edge k.
- Display latency: the seg/an/dp registers reflect the new buffer at edge k+1 if idx selects that digit.
- Enter: value and enter are both updated at edge k. enter is high for exactly one cycle.
- Back-to-back strobes on consecutive cycles are each processed in order; there is no drop.
- Key strobes and scan advances on the same edge are independent. Both take effect.
- Scan period: each digit is lit for exactly REFRESH_CYCLES cycles. The full frame is NDIGITS*REFRESH_CYCLES cycles.
- Reset asserted mid-entry or mid-scan: all state clears immediately (asynchronous), and outputs take their reset values without waiting for clk. Release is synchronous to the next clk edge.

## Configuration
- KBDISP_LZB_EN defined: leading-zero blanking is enabled. For idx>=cnt with cnt>0, the selected digit outputs seg=7'b1111111; its an is still driven low. With cnt=0, only digit 0 shows "0" and all others are blank.
- KBDISP_LZB_EN undefined: every digit always shows its nibble, so unentered positions display "0".
- value, enter and full are identical in both builds.

## Test plan
- Reset and scan, NDIGITS=4, REFRESH_CYCLES=4: after release, an sequences 1110→1101→1011→0111→1110, with each value held 4 cycles; seg=7'b1000000 throughout (no LZB).
- Entry: strobes 1,2,3 then 0xF → value=16'h0123, enter high exactly 1 cycle, cnt back to 0; with LZB, before enter, digit 3 is blank while digits 2..0 show 1,2,3.
- Overflow: strobes 9,8,7,6,5 → buffer 0x9876, full=1, fifth key ignored; dp=0 only while an=1110.
- Backspace and clear: enter 4,5, then 0xA → buffer 0x0004, cnt 1. Two more 0xA → buffer 0x0000, cnt 0 (no underflow). Enter 7, then 0xC → buffer 0.
- Ignored codes and back-to-back: strobes 0xB, 0xE, then consecutive-cycle 3,3 → buffer 0x0033, cnt 2.
- Async reset mid-entry: after 2 digits, pulse rst low between clk edges → all outputs at reset values before the next edge; value=0.

Source files
------------

// File: rtl/kb_digit_display.sv
// kb_digit_display: keypad entry buffer with a time-multiplexed 7-segment display.
// Define KBDISP_LZB_EN to blank unentered leading digits.
module kb_digit_display #(
  parameter int NDIGITS        = 4,
  parameter int REFRESH_CYCLES = 100_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  input  logic [3:0]           key_code,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [NDIGITS-1:0]   an,
  output logic [4*NDIGITS-1:0] value,
  output logic                 enter,
  output logic                 full
);

  localparam int BW = 4 * NDIGITS;
  localparam int CW = $clog2(NDIGITS + 1);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int RW = $clog2(REFRESH_CYCLES);

  localparam logic [CW-1:0] CMAX = CW'(NDIGITS);
  localparam logic [IW-1:0] IMAX = IW'(NDIGITS - 1);
  localparam logic [RW-1:0] RMAX = RW'(REFRESH_CYCLES - 1);

  logic [BW-1:0] ebuf_q, ebuf_d, kc_ext;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q;
  logic [IW-1:0] idx_q;

  logic is_dig, is_bs, is_clr, is_ent;

  logic [3:0]         nib;
  logic [6:0]         seg_d;
  logic               dp_d;
  logic [NDIGITS-1:0] an_d;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign is_dig = key_valid && (key_code <= 4'd9);
  assign is_bs  = key_valid && (key_code == 4'hA);
  assign is_clr = key_valid && (key_code == 4'hC);
  assign is_ent = key_valid && (key_code == 4'hF);

  assign full = (cnt_q == CMAX);

  always_comb begin
    kc_ext      = '0;
    kc_ext[3:0] = key_code;
    ebuf_d      = ebuf_q;
    cnt_d       = cnt_q;
    unique case (1'b1)
      is_dig: begin
        if (!full) begin
          ebuf_d = (ebuf_q << 4) | kc_ext;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      is_bs: begin
        if (cnt_q != '0) begin
          ebuf_d = ebuf_q >> 4;
          cnt_d  = cnt_q - CW'(1);
        end
      end
      is_clr, is_ent: begin
        ebuf_d = '0;
        cnt_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ebuf_q <= '0;
      cnt_q  <= '0;
      value  <= '0;
      enter  <= 1'b0;
    end else begin
      ebuf_q <= ebuf_d;
      cnt_q  <= cnt_d;
      enter  <= is_ent;
      if (is_ent) value <= ebuf_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt_q <= '0;
      idx_q  <= '0;
    end else if (rcnt_q == RMAX) begin
      rcnt_q <= '0;
      idx_q  <= (idx_q == IMAX) ? '0 : idx_q + IW'(1);
    end else begin
      rcnt_q <= rcnt_q + RW'(1);
    end
  end

  always_comb begin
    nib  = 4'd0;
    an_d = '1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib     = ebuf_q[4*i +: 4];
        an_d[i] = 1'b0;
      end
    end
    seg_d = hex7(nib);
`ifdef KBDISP_LZB_EN
    if ((cnt_q == '0) ? (idx_q != '0) : (8'(idx_q) >= 8'(cnt_q)))
      seg_d = 7'b1111111;
`endif
    dp_d = !((idx_q == '0) && full);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= ~NDIGITS'(1);
      seg <= 7'b1000000;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule
